// File: rtl/rf_stim_gen_pkg.sv
// rf_stim_pkg: shared state encoding, RF write-source codes and LFSR constants
// for the register-file stimulus generator.
package rf_stim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        RANDOM = 2'd2,
        DONE   = 2'd3
    } stim_state_t;

    localparam logic [1:0]  SRC_IMM      = 2'b00;
    localparam logic [1:0]  SRC_ALU      = 2'b01;
    localparam logic [1:0]  SRC_EXT      = 2'b10;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
    endfunction

    // Source code 11 is not a legal RF source; fold it onto the immediate path.
    function automatic logic [1:0] fix_src(input logic [1:0] s);
        return (s == 2'b11) ? SRC_IMM : s;
    endfunction

endpackage

// File: rtl/rf_stim_gen_if.sv
// rf_stim_gen_if: valid/ready beat bus between the stimulus generator and the
// register-file datapath / access scoreboard.
interface rf_stim_gen_if #(
    parameter int N           = 8,
    parameter int addressBits = 2
);
    logic                   valid;
    logic                   ready;
    logic [1:0]             selectSource;
    logic                   write_en;
    logic [addressBits-1:0] writeAddress;
    logic [addressBits-1:0] readAddressA;
    logic [addressBits-1:0] readAddressB;
    logic [N-1:0]           imm_data;

    modport master (
        output valid, selectSource, write_en, writeAddress,
               readAddressA, readAddressB, imm_data,
        input  ready
    );

    modport slave (
        input  valid, selectSource, write_en, writeAddress,
               readAddressA, readAddressB, imm_data,
        output ready
    );
endinterface

// File: rtl/rf_stim_gen_lfsr.sv
// rf_stim_lfsr: 16-bit Galois LFSR (mask 16'hB400) with load and step enables.
// A zero seed would lock up the register, so it is replaced by the default seed.
module rf_stim_lfsr
    import rf_stim_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        step_i,
    output logic [15:0] lfsr_o,
    output logic [15:0] next_o
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr_q <= SEED_EFF;
        end else if (load_i) begin
            lfsr_q <= SEED_EFF;
        end else if (step_i) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q;
    assign next_o = lfsr_step(lfsr_q);
endmodule

// File: rtl/rf_stim_gen.sv
// rf_stim_gen: register-file beat generator; write sweep of every register, then
// LFSR-random beats. Build macro STIM_COVER_EN adds read-coverage steering and cover_full.
module rf_stim_gen
    import rf_stim_pkg::*;
#(
    parameter int          N           = 8,
    parameter int          addressBits = 2,
    parameter int          NUM_TXN     = 64,
    parameter logic [15:0] SEED        = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    rf_stim_gen_if.master bus,
    output logic          busy,
    output logic          done,
`ifdef STIM_COVER_EN
    output logic          cover_full,
`endif
    output logic [15:0]   txn_count
);
    // state  | meaning
    // IDLE   | waiting for start, no beat presented
    // SWEEP  | beat i writes register i with imm_data = i
    // RANDOM | beat fields taken from the LFSR
    // DONE   | one cycle after the last accept; done pulses, start may rerun

    localparam int          REGS      = 2 ** addressBits;
    localparam logic [15:0] LAST_CNT  = 16'(NUM_TXN);
    localparam logic [15:0] SWEEP_LEN = 16'(REGS);

    stim_state_t            state_q;
    logic                   valid_q, write_en_q, busy_q, done_q;
    logic [1:0]             src_q;
    logic [addressBits-1:0] wa_q, ra_q, rb_q;
    logic [N-1:0]           imm_q;
    logic [15:0]            cnt_q;

    logic                   idle_like, accept, lfsr_load, lfsr_step_en;
    logic [15:0]            lfsr_q, lfsr_next, rnd_l, cnt_inc, sweep_idx;
    logic [addressBits-1:0] rnd_ra_d;

    assign idle_like    = (state_q == IDLE) || (state_q == DONE);
    assign accept       = valid_q & bus.ready;
    assign cnt_inc      = cnt_q + 16'd1;
    assign lfsr_load    = idle_like & start;
    assign lfsr_step_en = accept & (state_q == RANDOM);
    assign sweep_idx    = idle_like ? 16'd0 : cnt_inc;
    // First random beat uses L as loaded; later ones use L after this accept's step.
    assign rnd_l        = (state_q == RANDOM) ? lfsr_next : lfsr_q;

    rf_stim_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (lfsr_load),
        .step_i (lfsr_step_en),
        .lfsr_o (lfsr_q),
        .next_o (lfsr_next)
    );

`ifdef STIM_COVER_EN
    logic [REGS-1:0]        map_q, map_upd;
    logic [addressBits-1:0] low_free;
    logic                   any_free;

    assign map_upd = map_q | (REGS'(1) << ra_q) | (REGS'(1) << rb_q);

    always_comb begin
        low_free = '0;
        any_free = 1'b0;
        for (int i = REGS - 1; i >= 0; i--) begin
            if (!map_upd[i]) begin
                low_free = addressBits'(i);
                any_free = 1'b1;
            end
        end
        rnd_ra_d = rnd_l[2*addressBits:addressBits+1];
        if (map_upd[rnd_ra_d] && any_free) begin
            rnd_ra_d = low_free;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            map_q <= '0;
        end else if (lfsr_load) begin
            map_q <= '0;
        end else if (accept) begin
            map_q <= map_upd;
        end
    end

    assign cover_full = &map_q;
`else
    assign rnd_ra_d = rnd_l[2*addressBits:addressBits+1];
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            write_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_q      <= SRC_IMM;
            wa_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            imm_q      <= '0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start) begin
                        state_q    <= SWEEP;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        write_en_q <= 1'b1;
                        src_q      <= SRC_IMM;
                        wa_q       <= sweep_idx[addressBits-1:0];
                        ra_q       <= sweep_idx[addressBits-1:0];
                        rb_q       <= sweep_idx[addressBits-1:0];
                        imm_q      <= N'(sweep_idx);
                    end
                end
                SWEEP, RANDOM: begin
                    if (accept) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if ((state_q == SWEEP) && (cnt_inc < SWEEP_LEN)) begin
                            write_en_q <= 1'b1;
                            src_q      <= SRC_IMM;
                            wa_q       <= sweep_idx[addressBits-1:0];
                            ra_q       <= sweep_idx[addressBits-1:0];
                            rb_q       <= sweep_idx[addressBits-1:0];
                            imm_q      <= N'(sweep_idx);
                        end else begin
                            state_q    <= RANDOM;
                            write_en_q <= rnd_l[0];
                            src_q      <= fix_src(rnd_l[15:14]);
                            wa_q       <= rnd_l[addressBits:1];
                            ra_q       <= rnd_ra_d;
                            rb_q       <= rnd_l[3*addressBits:2*addressBits+1];
                            imm_q      <= rnd_l[N-1:0];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.valid        = valid_q;
    assign bus.write_en     = write_en_q;
    assign bus.selectSource = src_q;
    assign bus.writeAddress = wa_q;
    assign bus.readAddressA = ra_q;
    assign bus.readAddressB = rb_q;
    assign bus.imm_data     = imm_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign txn_count        = cnt_q;
endmodule

// File: tb/tb_rf_stim_gen.sv
// Scoreboard bench for rf_stim_gen (N=8, addressBits=2, NUM_TXN=8, seed 16'hACE1):
// expected beats are queued per run and a negedge monitor pops one per accept.
module tb_rf_stim_gen;
    localparam int N  = 8;
    localparam int AW = 2;
    localparam int NT = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] txn_count;
`ifdef STIM_COVER_EN
    logic        cover_full;
`endif

    rf_stim_gen_if #(.N(N), .addressBits(AW)) bus ();

    rf_stim_gen #(.N(N), .addressBits(AW), .NUM_TXN(NT), .SEED(16'hACE1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
`ifdef STIM_COVER_EN
        .cover_full(cover_full),
`endif
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [1:0] sel;
        logic [1:0] wa;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] imm;
    } beat_t;

    beat_t golden [NT];
    beat_t exp_q [$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_acc = 0;

    function automatic beat_t cur_beat();
        return '{we: bus.write_en, sel: bus.selectSource, wa: bus.writeAddress,
                 ra: bus.readAddressA, rb: bus.readAddressB, imm: bus.imm_data};
    endfunction

    // Monitor: the beat seen with valid & ready at negedge is accepted at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n && bus.valid && bus.ready) begin
            beat_t act, e;
            act = cur_beat();
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat%0d unexpected: got %h, nothing expected", n_acc, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL beat%0d: got %h want %h", n_acc, act, e);
                end
            end
            n_acc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run();
        for (int i = 0; i < NT; i++) exp_q.push_back(golden[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_cnt(input int k);
        int c = 0;
        while (txn_count != 16'(k) && c < 40) begin
            tick();
            c++;
        end
        check("wait_txn_count", {16'd0, txn_count}, k);
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        check("done_seen", {31'd0, done}, 1);
    endtask

    initial begin
        beat_t hold;
        int    prev;

        // we, sel, wa, ra, rb, imm; beats 4..7 from L = ACE1, E270, 7138, 389C
        golden[0] = '{1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 8'h00};
        golden[1] = '{1'b1, 2'd0, 2'd1, 2'd1, 2'd1, 8'h01};
        golden[2] = '{1'b1, 2'd0, 2'd2, 2'd2, 2'd2, 8'h02};
        golden[3] = '{1'b1, 2'd0, 2'd3, 2'd3, 2'd3, 8'h03};
        golden[4] = '{1'b1, 2'd2, 2'd0, 2'd0, 2'd3, 8'hE1};
        golden[5] = '{1'b0, 2'd0, 2'd0, 2'd2, 2'd3, 8'h70};
        golden[6] = '{1'b0, 2'd1, 2'd0, 2'd3, 2'd1, 8'h38};
        golden[7] = '{1'b0, 2'd0, 2'd2, 2'd3, 2'd0, 8'h9C};

        bus.ready = 1'b0;
        #12;
        check("rst_valid", {31'd0, bus.valid}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_done",  {31'd0, done}, 0);
        check("rst_count", {16'd0, txn_count}, 0);

        @(negedge clk);
        rst_n     = 1'b0;
        bus.ready = 1'b1;
        tick(); tick(); tick();
        check("idle_ready_count", {16'd0, txn_count}, 0);
        check("idle_valid", {31'd0, bus.valid}, 0);

        // Run 1: stall at beat 2, then complete.
        push_run();
        pulse_start();
        check("start_valid", {31'd0, bus.valid}, 1);
        check("start_busy",  {31'd0, busy}, 1);
        tick();
        tick();
        bus.ready = 1'b0;
        hold = cur_beat();
        check("stall_beat2", 32'(hold), 32'(golden[2]));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_count", {16'd0, txn_count}, 2);
            check("stall_hold", 32'(cur_beat()), 32'(hold));
            check("stall_valid", {31'd0, bus.valid}, 1);
        end
        bus.ready = 1'b1;
        wait_done();
        check("done_busy",  {31'd0, busy}, 0);
        check("done_valid", {31'd0, bus.valid}, 0);
        check("done_count", {16'd0, txn_count}, 8);
        check("run1_accepts", n_acc, 8);
`ifdef STIM_COVER_EN
        check("cover_full", {31'd0, cover_full}, 1);
`endif
        tick();
        check("done_pulse", {31'd0, done}, 0);
        check("final_count_hold", {16'd0, txn_count}, 8);
        check("run1_queue_empty", exp_q.size(), 0);

        // Run 2: asynchronous abort after 5 accepts.
        n_acc = 0;
        push_run();
        pulse_start();
        wait_cnt(5);
        #2 rst_n = 1'b1;
        #1;
        check("abort_valid", {31'd0, bus.valid}, 0);
        check("abort_busy",  {31'd0, busy}, 0);
        check("abort_count", {16'd0, txn_count}, 0);
        check("abort_accepts", n_acc, 5);
        exp_q.delete();

        // Run 3: replay after abort, start pulsed mid-run must be ignored.
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        n_acc = 0;
        push_run();
        pulse_start();
        wait_cnt(3);
        prev = int'(txn_count);
        pulse_start();
        check("busy_start_busy", {31'd0, busy}, 1);
        check("busy_start_count", {16'd0, txn_count}, prev + 1);
        wait_done();
        check("run3_count", {16'd0, txn_count}, 8);
        check("run3_accepts", n_acc, 8);
        tick();
        check("run3_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
